// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// Helpers work on a fixed 32-bit vector, which is the widest supported
// requester count. Callers zero-extend their N-bit values on the way in
// and truncate the result on the way out.
package rr_arb_pkg;

    localparam int RR_MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector. Returns 0 for all-zero.
    function automatic int onehot2idx(input logic [RR_MAX_N-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Rotate a one-hot vector left by one position within its low n bits.
    // Bit n-1 wraps around to bit 0.
    function automatic logic [RR_MAX_N-1:0] rotl1(input logic [RR_MAX_N-1:0] v,
                                                  input int n);
        logic [RR_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (i == n - 1) begin
                r[0] = v[i];
            end else if (i < n - 1) begin
                r[i+1] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Requester/resource bundle for rr_ring_arbiter.
// The master modport is the requesting side and drives req and done.
// The slave modport is the arbiter and returns the grant outputs.
interface rr_ring_arbiter_if #(
    parameter int N = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );
endinterface

// File: rtl/ring_pointer.sv
// N-bit one-hot priority pointer.
// Resets to bit 0. When ld is high, it loads nxt on the next clock edge.
module ring_pointer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld,
    input  logic [N-1:0] nxt,
    output logic [N-1:0] ptr
);
    logic [N-1:0] ptr_q;
    logic [N-1:0] ptr_d;

    // Hold the current pointer unless a new one is being loaded.
    always_comb begin
        ptr_d = ptr_q;
        if (ld) begin
            ptr_d = nxt;
        end
    end

    // Pointer register with asynchronous reset to requester 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= N'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// Optional feature: define RR_ARB_TIMEOUT_EN to cap each grant at
// MAX_HOLD cycles and pulse timeout on a forced release.
// All outputs come straight from flops.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rstn,
    rr_ring_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   ptr;
    logic           ptr_ld;
    logic [N-1:0]   ptr_nxt;

    logic [N-1:0]   req_hi;
    logic [N-1:0]   pick_src;
    logic [N-1:0]   sel_oh;
    logic           owner_req;
    logic           expire;

    ring_pointer #(.N(N)) u_ptr (
        .clk  (clk),
        .rstn (rstn),
        .ld   (ptr_ld),
        .nxt  (ptr_nxt),
        .ptr  (ptr)
    );

    // Circular search starting at the pointer. Requests at or above the
    // pointer win first; if none exist, the search wraps to the lowest
    // requester. The lowest set bit is isolated with x & -x.
    always_comb begin
        req_hi   = bus.req & ~(ptr - N'(1));
        pick_src = (|req_hi) ? req_hi : bus.req;
        sel_oh   = pick_src & (~pick_src + N'(1));
    end

    // The owner still holds its request if its bit in req is set.
    assign owner_req = |(bus.req & gnt_q);

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    // Count cycles spent in GRANT. The counter is cleared while idle,
    // so each grant starts again from zero.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = hold_q + HW'(1);
        end
    end

    // Hold-counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign expire = (state_q == GRANT) && (hold_q == HOLD_LAST);
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 1);
    assign expire          = 1'b0;
`endif

    // Next-state logic: grant from IDLE, release from GRANT.
    // The pointer rotates past the owner on any release.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_ld    = 1'b0;
        ptr_nxt   = ptr;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = GRANT;
                    gnt_d    = sel_oh;
                    gnt_id_d = IDW'(onehot2idx(RR_MAX_N'(sel_oh)));
                    busy_d   = 1'b1;
                end
            end
            GRANT: begin
                if (bus.done || !owner_req || expire) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_ld    = 1'b1;
                    ptr_nxt   = N'(rotl1(RR_MAX_N'(gnt_q), N));
                    // Only a release caused by the timer alone counts as forced.
                    timeout_d = expire && !bus.done && owner_req;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: doc/rr_ring_arbiter.md
# rr_ring_arbiter

Round-robin arbiter that shares one resource among `N` requesters. A one-hot priority pointer rotates like a ring counter. The pointer advances past each requester once its grant is released, so every active requester is served within `N` grants. The arbiter sits between requesting engines and the shared resource; the resource signals completion with `done`.

## Interface
- `N`, 8, number of requesters; range 2..32.
- `MAX_HOLD`, 16, maximum grant length in cycles; used only with `RR_ARB_TIMEOUT_EN`; range ≥2.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request level.
- `done`  in  1  resource finished; single-cycle pulse; meaningful only in GRANT.
- `gnt`  out  N  one-hot grant, registered; all-zero when idle.
- `gnt_id`  out  $clog2(N)  index of the granted requester, registered; holds its last value when idle.
- `busy`  out  1  high while in GRANT; equal to `|gnt`.
- `timeout`  out  1  one-cycle pulse on a forced release; constant 0 when the macro is off.

## Operation
- Reset values (asynchronous): state=IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, pointer=one-hot bit 0, hold counter=0.
- Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- Pointer: one-hot, `N` bits. It marks the highest-priority requester.
- Selection: circular search starting at the pointer bit, upward with wrap from `N-1` to 0. The first set `req` bit wins.
- States:
  - IDLE:
    - `req`==0 → stay in IDLE.
    - Otherwise → GRANT, loading `gnt`/`gnt_id` with the selected requester.
  - GRANT, with owner = `gnt_id`. Any of these release the grant:
    - `done`==1 → release.
    - `req[owner]`==0 → release; the requester abandoned the grant.
    - Timeout expiry (macro on) → release and pulse `timeout`.
- On release, next edge:
  - `gnt`=0, `busy`=0, state=IDLE.
  - Pointer = one-hot of (owner+1) mod `N`, i.e. the owner's bit rotated left by one.
- Requests from non-owners during GRANT are ignored; they are not queued, only re-sampled in IDLE.
- `done` sampled while in IDLE is ignored.
- Release and a new request on the same edge: release only. The new request is arbitrated in the following IDLE cycle.
- `gnt` is never multi-hot. `gnt` never changes owner without passing through IDLE.

## Timing
- Grant latency: `req` sampled high at IDLE edge k → `gnt` high after edge k.
- Release latency: release condition sampled at edge k → `gnt` low after edge k.
- Exactly one idle cycle between consecutive grants. Maximum throughput is one grant per (hold+1) cycles.
- Starvation bound: a continuously requesting input is granted within `N-1` other grants.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter of width $clog2(`MAX_HOLD`+1) clears on entry to GRANT and increments each GRANT cycle.
  - Grant length is capped at `MAX_HOLD` cycles: `gnt` is high for exactly `MAX_HOLD` cycles if there is no earlier release.
  - The forced release follows the normal release rules, including pointer rotation.
  - `timeout` is a one-cycle pulse coincident with the first idle cycle.
  - If `done` and expiry occur on the same edge, the release counts as normal and `timeout` stays 0.
- Undefined:
  - No counter is built. Grants are unbounded.
  - `timeout` is tied to 0.

## Structure
- Package `rr_arb_pkg`:
  - State enum {IDLE, GRANT}.
  - Function `onehot2idx`.
  - Function `rotl1` (one-hot rotate).
- Sub-module `ring_pointer`:
  - Parameterised `N`-bit one-hot register.
  - Async reset to bit 0; load-enable with next-value input.
  - Instantiated once for the priority pointer.
- Top level holds the selection logic, FSM, output registers and the optional hold counter.

## Test plan
- Reset and idle: `rstn`=0 with `req`=8'hFF → `gnt`=0, `gnt_id`=0, `busy`=0. After release with `req`=0 → no grant for 5 cycles.
- Single requester: `req`=8'h08 → `gnt`=8'h08, `gnt_id`=3 one edge later. `done` pulse → `gnt`=0 next edge; pointer=8'h10.
- Fairness and wrap: `req`=8'hFF held, `done` pulsed on the second cycle of each grant → grant order 0,1,…,7,0 with one idle cycle between grants.
- Circular search and abandonment: pointer=8'h10, `req`=8'h05 → grant id 0, then `req[0]` dropped with no `done` → release; next grant id 2.
- Timeout (`MAX_HOLD`=16, macro on): `req`=8'h01 held, no `done` → `gnt` high exactly 16 cycles, `timeout`=1 for 1 cycle; with the macro off, `gnt` stays high indefinitely.
- Async reset mid-grant: `rstn` low between clock edges → `gnt`=0 and `busy`=0 immediately. After `rstn` rises, pointer=8'h01 and the first grant goes to the lowest set `req` bit.
